// File: rtl/div_sequencer_unit.sv
// div_sequencer_unit
// Multi-cycle sequencer and restoring-division datapath for RV32IM
// DIV/DIVU/REM/REMU in the EX stage. One operation is accepted per START
// pulse in IDLE. The pipeline is held with STALL while the divider works.
// The result is presented as a registered RESULT with a one-cycle DONE pulse.
//
// Optional build macro: DIV_EARLY_OUT_EN
//   When defined, a zero divisor or signed overflow jumps straight from IDLE
//   to FIX, which gives a one-cycle latency for those cases. When undefined,
//   every operation runs all 32 iterations. Results are identical in both builds.

module div_sequencer_unit #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [1:0]      DIV_OP,
    input  logic [XLEN-1:0] OPERAND1,
    input  logic [XLEN-1:0] OPERAND2,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            STALL,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    // Two's-complement negation of a data word
    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
        return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   quot_q, quot_d;       // dividend shifting out, quotient shifting in
    logic [XLEN-1:0]   prem_q, prem_d;       // partial remainder (always < divisor)
    logic [XLEN-1:0]   divisor_q, divisor_d;
    logic [XLEN-1:0]   raw_op1_q, raw_op1_d; // unmodified dividend for the divide-by-zero remainder
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic              div_zero_q, div_zero_d;
    logic              ovf_q, ovf_d;

    logic              is_signed_s;
    logic              sign1_s;
    logic              sign2_s;
    logic [XLEN-1:0]   abs1_s;
    logic [XLEN-1:0]   abs2_s;
    logic              dz_in_s;
    logic              ovf_in_s;
    logic [XLEN:0]     p_shift_s;
    logic [XLEN-1:0]   q_shift_s;
    logic [XLEN-1:0]   q_fix_s;
    logic [XLEN-1:0]   r_fix_s;

    // Decode the incoming operation: operand signs, magnitudes and special cases
    always_comb begin
        is_signed_s = ~DIV_OP[0];
        sign1_s     = is_signed_s & OPERAND1[XLEN-1];
        sign2_s     = is_signed_s & OPERAND2[XLEN-1];
        if (sign1_s) begin
            abs1_s = neg_w(OPERAND1);
        end else begin
            abs1_s = OPERAND1;
        end
        if (sign2_s) begin
            abs2_s = neg_w(OPERAND2);
        end else begin
            abs2_s = OPERAND2;
        end
        dz_in_s  = (OPERAND2 == {XLEN{1'b0}});
        ovf_in_s = is_signed_s
                 & (OPERAND1 == {1'b1, {(XLEN-1){1'b0}}})
                 & (OPERAND2 == {XLEN{1'b1}});
    end

    // One restoring-division step plus the sign/special-case fix-up of the final values
    always_comb begin
        p_shift_s = {prem_q, quot_q[XLEN-1]};
        q_shift_s = {quot_q[XLEN-2:0], 1'b0};
        if (div_zero_q) begin
            q_fix_s = {XLEN{1'b1}};
            r_fix_s = raw_op1_q;
        end else if (ovf_q) begin
            q_fix_s = {1'b1, {(XLEN-1){1'b0}}};
            r_fix_s = {XLEN{1'b0}};
        end else begin
            if (q_neg_q) begin
                q_fix_s = neg_w(quot_q);
            end else begin
                q_fix_s = quot_q;
            end
            if (r_neg_q) begin
                r_fix_s = neg_w(prem_q);
            end else begin
                r_fix_s = prem_q;
            end
        end
    end

    // Next-state, datapath and output computation for the sequencer
    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        result_d   = result_q;
        op_d       = op_q;
        quot_d     = quot_q;
        prem_d     = prem_q;
        divisor_d  = divisor_q;
        raw_op1_d  = raw_op1_q;
        cnt_d      = cnt_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (START && !FLUSH) begin
                    op_d       = DIV_OP;
                    quot_d     = abs1_s;
                    divisor_d  = abs2_s;
                    raw_op1_d  = OPERAND1;
                    prem_d     = {XLEN{1'b0}};
                    cnt_d      = CW'(XLEN - 1);
                    q_neg_d    = sign1_s ^ sign2_s;
                    r_neg_d    = sign1_s;
                    div_zero_d = dz_in_s;
                    ovf_d      = ovf_in_s;
`ifdef DIV_EARLY_OUT_EN
                    if (dz_in_s || ovf_in_s) begin
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_CALC;
                    end
`else
                    state_d = ST_CALC;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (FLUSH) begin
                    state_d = ST_IDLE;
                end else begin
                    // Remainder after a successful subtract always fits in XLEN bits
                    if (p_shift_s >= {1'b0, divisor_q}) begin
                        prem_d = p_shift_s[XLEN-1:0] - divisor_q;
                        quot_d = q_shift_s | {{(XLEN-1){1'b0}}, 1'b1};
                    end else begin
                        prem_d = p_shift_s[XLEN-1:0];
                        quot_d = q_shift_s;
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == {CW{1'b0}}) begin
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_FIX: begin
                if (FLUSH) begin
                    state_d = ST_IDLE;
                end else begin
                    if (op_q[1]) begin
                        result_d = r_fix_s;
                    end else begin
                        result_d = q_fix_s;
                    end
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and registered outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= {XLEN{1'b0}};
            op_q       <= 2'b00;
            quot_q     <= {XLEN{1'b0}};
            prem_q     <= {XLEN{1'b0}};
            divisor_q  <= {XLEN{1'b0}};
            raw_op1_q  <= {XLEN{1'b0}};
            cnt_q      <= {CW{1'b0}};
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            op_q       <= op_d;
            quot_q     <= quot_d;
            prem_q     <= prem_d;
            divisor_q  <= divisor_d;
            raw_op1_q  <= raw_op1_d;
            cnt_q      <= cnt_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RESULT = result_q;
    // Hold the pipeline in the issue cycle as well as while busy; a flush cancels the issue
    assign STALL  = busy_q | (START & (state_q == ST_IDLE) & ~FLUSH);

endmodule

// File: tb/tb_div_sequencer_unit.sv
// Directed self-checking bench for div_sequencer_unit.
module tb_div_sequencer_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  div_op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int SP_LAT = 1;
`else
    localparam int SP_LAT = 33;
`endif

    div_sequencer_unit #(.XLEN(32)) dut (
        .CLK      (clk),
        .RESET    (rst_n),
        .START    (start),
        .DIV_OP   (div_op),
        .OPERAND1 (op1),
        .OPERAND2 (op2),
        .FLUSH    (flush),
        .BUSY     (busy),
        .STALL    (stall),
        .DONE     (done),
        .RESULT   (result)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op (caller is 1 time unit after a rising edge, block idle) and check it
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
        int lat;
        int busy_n;
        int stall_n;
        start  = 1'b1;
        div_op = op;
        op1    = a;
        op2    = b;
        #1;
        check({tag, "_stall_issue"}, 32'(stall), 32'd1);
        @(posedge clk); #1;
        start   = 1'b0;
        lat     = 0;
        busy_n  = 0;
        stall_n = 0;
        while (!done && lat < 100) begin
            if (busy)  busy_n++;
            if (stall) stall_n++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, result, exp_res);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_lat));
        check({tag, "_stall_cycles"}, 32'(stall_n), 32'(exp_lat));
        check({tag, "_stall_done"}, 32'(stall), 32'd0);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int dn;
        rst_n  = 1'b0;
        start  = 1'b0;
        div_op = 2'b00;
        op1    = 32'd0;
        op2    = 32'd0;
        flush  = 1'b0;

        // Reset state and STALL following START while in reset
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        start = 1'b1;
        #1;
        check("rst_stall_follows_start", 32'(stall), 32'd1);
        start = 1'b0;
        #1;
        check("rst_stall_low", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 32'd0);

        // Basic signed/unsigned division and remainder
        do_op("div_100_7",  2'b00, 32'd100, 32'd7, 33, 32'd14);
        do_op("rem_100_7",  2'b10, 32'd100, 32'd7, 33, 32'd2);
        do_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
        do_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
        do_op("divu_max_2", 2'b01, 32'hFFFF_FFFF, 32'd2, 33, 32'h7FFF_FFFF);
        do_op("remu_max_2", 2'b11, 32'hFFFF_FFFF, 32'd2, 33, 32'd1);
        do_op("div_7_m2",   2'b00, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD);

        // Divide by zero
        do_op("div_5_0",    2'b00, 32'd5, 32'd0, SP_LAT, 32'hFFFF_FFFF);
        do_op("divu_5_0",   2'b01, 32'd5, 32'd0, SP_LAT, 32'hFFFF_FFFF);
        do_op("rem_5_0",    2'b10, 32'd5, 32'd0, SP_LAT, 32'd5);
        do_op("remu_5_0",   2'b11, 32'd5, 32'd0, SP_LAT, 32'd5);
        do_op("rem_m7_0",   2'b10, 32'hFFFF_FFF9, 32'd0, SP_LAT, 32'hFFFF_FFF9);

        // Signed overflow, and the same operands unsigned (not a special case)
        do_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, SP_LAT, 32'h8000_0000);
        do_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, SP_LAT, 32'd0);
        do_op("divu_novf",  2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0);
        do_op("remu_novf",  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000);

        // Known RESULT before the flush test
        do_op("div_pre_flush", 2'b00, 32'd100, 32'd7, 33, 32'd14);

        // FLUSH at cycle 10 of CALC
        start  = 1'b1;
        div_op = 2'b00;
        op1    = 32'd1000;
        op2    = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("flush_pre_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        dn = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        check("flush_no_done", 32'(dn), 32'd0);
        check("flush_result_kept", result, 32'd14);

        // FLUSH and START together
        start  = 1'b1;
        flush  = 1'b1;
        div_op = 2'b01;
        op1    = 32'd20;
        op2    = 32'd4;
        #1;
        check("flush_start_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_busy", 32'(busy), 32'd0);
        dn = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        check("flush_start_no_done", 32'(dn), 32'd0);
        check("flush_start_result", result, 32'd14);

        // Back-to-back: new START in the DONE cycle
        start  = 1'b1;
        div_op = 2'b00;
        op1    = 32'd100;
        op2    = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_first_latency", 32'(lat), 32'd33);
        check("b2b_first_result", result, 32'd14);
        start  = 1'b1;
        div_op = 2'b01;
        op1    = 32'd50;
        op2    = 32'd5;
        #1;
        check("b2b_stall_in_done", 32'(stall), 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_done_spacing", 32'(lat), 32'd34);
        check("b2b_second_result", result, 32'd10);
        @(posedge clk); #1;

        // RESET pulled low at cycle 20 of an op
        start  = 1'b1;
        div_op = 2'b00;
        op1    = 32'd100;
        op2    = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        dn = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        check("midrst_no_done", 32'(dn), 32'd0);
        rst_n = 1'b1;
        do_op("div_9_3_after_rst", 2'b00, 32'd9, 32'd3, 33, 32'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/div_sequencer_unit.md
# div_sequencer_unit

Multi-cycle sequencer and datapath for the RV32IM division instructions (DIV, DIVU, REM, REMU) in the EX stage. It accepts one operation per START pulse and runs a 32-iteration restoring divider. While it works, it holds the pipeline with STALL and then presents a registered 32-bit RESULT with a one-cycle DONE pulse. Multiply ops stay in the single-cycle ALU and never reach this block.

## Interface
- XLEN, 32, operand/result width; only 32 is supported
- CLK  input  1  clock; all state updates on rising edge
- RESET  input  1  reset, asynchronous, active-low
- START  input  1  request from ID/EX; sampled only in IDLE
- DIV_OP  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with START
- OPERAND1  input  32  dividend (rs1); sampled with START
- OPERAND2  input  32  divisor (rs2); sampled with START
- FLUSH  input  1  synchronous abort (branch mispredict / trap)
- BUSY  output  1  registered; high whenever state is not IDLE
- STALL  output  1  combinational: BUSY | (START & state==IDLE & ~FLUSH)
- DONE  output  1  registered; one-cycle completion pulse
- RESULT  output  32  registered quotient or remainder; holds until next completion

## Operation
- States: IDLE, CALC, FIX.
- IDLE, START=1, FLUSH=0:
  - latch DIV_OP
  - latch |OPERAND1| and |OPERAND2| (absolute values only for DIV/REM)
  - latch quotient sign = sign1^sign2 (signed ops) and remainder sign = sign1 (signed ops)
  - clear partial remainder; set iteration counter to 31; go to CALC
- CALC, each cycle:
  - partial remainder P = {P[31:0], Q[31]}, 33 bits; Q shifted left
  - if P >= divisor: P -= divisor, Q[0]=1; else Q[0]=0
  - counter decrements; after the counter==0 iteration, go to FIX
- FIX:
  - negate Q if quotient sign set; negate P if remainder sign set
  - RESULT <= Q for DIV/DIVU, P[31:0] for REM/REMU
  - DONE <= 1; go to IDLE
- Special results (RISC-V mandated, must hold in every build):
  - divisor 0: quotient 0xFFFFFFFF (DIV and DIVU); remainder = OPERAND1 unmodified
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0
  - Sign fix-up must not alter these; FIX applies the special values when the latched flags are set.
- START outside IDLE is ignored; the pipeline must not issue one, because STALL is high.
- FLUSH in CALC or FIX: state <= IDLE next edge, no DONE, RESULT unchanged.
- FLUSH and START in the same IDLE cycle: flush wins; nothing starts and STALL is low.

## Timing
- Reset (RESET low, immediate): state IDLE, BUSY 0, DONE 0, RESULT 0, counter 0, internal registers 0. STALL then follows START.
- Reset asserted mid-operation aborts with no DONE. After release, the block is idle on the first edge.
- Edge E0 samples START. BUSY is high from E0 through E33. DONE is high for exactly the cycle following E33. RESULT is valid from E33.
- Latency from START sample to DONE is 33 cycles. Throughput is one op per 34 cycles, since a new START is accepted in the DONE cycle.
- STALL is high in the START cycle and all BUSY cycles. It is low in the DONE cycle so that EX/MEM captures RESULT on E34.
- DONE is never asserted on two consecutive cycles.

## Configuration
- DIV_EARLY_OUT_EN defined:
  - divisor==0 or signed overflow, detected at E0, skips CALC: E0 -> FIX, E1 writes RESULT, DONE in the cycle after E1
  - latency 1 cycle for these cases
- Undefined: every op runs the full 33-cycle path with identical results.
- BUSY/STALL follow the state in both builds.

## Test plan
- DIV 100/7 (DIV_OP=00) -> DONE exactly 33 cycles after START, RESULT=14; DIV_OP=10 -> RESULT=2; STALL high 33 cycles, low in DONE cycle.
- REM 0xFFFFFFF9 (-7) / 2 -> RESULT=0xFFFFFFFF (-1); DIV -> 0xFFFFFFFD (-3); DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF; REMU -> 1.
- Divisor 0, OPERAND1=5: DIV and DIVU -> 0xFFFFFFFF; REM -> 5. Overflow 0x80000000/0xFFFFFFFF: DIV -> 0x80000000, REM -> 0. Latency 1 with DIV_EARLY_OUT_EN, 33 without.
- FLUSH at cycle 10 of CALC -> BUSY low next edge, no DONE, RESULT keeps previous value. FLUSH+START together -> no start, STALL low.
- Back-to-back: START again in the DONE cycle -> accepted; second DONE 34 cycles after the first.
- RESET pulled low at cycle 20 of an op -> outputs 0 immediately, no DONE. A fresh DIV 9/3 after release -> RESULT=3 in 33 cycles.
